uart_flit_deserializer: RTL and testbench

- Receive side of the UART flit link. Takes the byte stream from the UART receiver, assembles 16 bytes into one 128-bit flit_t and verifies the 16-bit checksum.
- Hands verified flits to the router input buffer over a valid/ready interface. Flits with a bad checksum or a stalled byte stream are dropped and flagged.
- Sits between the UART RX datapath and the flit_buffer_t ingress of the NoC node.

---
 rtl/uart_flit_deserializer.sv | 196 +++++++++++++++++++
 tb/tb_uart_flit_deserializer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_flit_deserializer.sv
// -----------------------------------------------------------------------------
// uart_flit_deserializer
//
// Receive side of the UART flit link. Collects 16 bytes from the UART RX
// datapath into one 128-bit flit, checks the 16-bit checksum carried in the
// last two bytes and hands good flits to the router ingress. Flits with a bad
// checksum, or partial flits whose byte stream stalls, are dropped. Each drop
// raises a one-cycle error pulse and bumps a saturating error counter.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds data stable while valid is
// high and ready is low. This block never makes ready depend on valid.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   byte_valid     in   UART RX byte available
//   byte_data[7:0] in   received byte
//   byte_ready     out  byte accepted this cycle (IDLE / RECEIVING only)
//   flit_valid     out  flit_out holds a verified flit
//   flit_out[127:0]out  assembled flit, byte 0 in bits [127:120]
//   flit_ready     in   downstream accepts flit_out
//   err_checksum   out  one-cycle pulse, flit dropped on checksum mismatch
//   err_timeout    out  one-cycle pulse, partial flit dropped on timeout
//   err_count      out  saturating count of dropped flits
//   busy           out  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module uart_flit_deserializer #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     flit_valid,
  output logic [127:0]             flit_out,
  input  logic                     flit_ready,
  output logic                     err_checksum,
  output logic                     err_timeout,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     busy
);

  localparam int FLIT_WIDTH = 128;
  localparam int FLIT_BYTES = FLIT_WIDTH / 8;
  localparam logic [3:0] LAST_IDX = 4'(FLIT_BYTES - 1);

  // The timeout counter only ever needs to reach TIMEOUT_CYCLES-1.
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RECEIVING = 2'd1,
    S_CHECK     = 2'd2,
    S_OUTPUT    = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [FLIT_WIDTH-1:0]    flit_q, flit_d;
  logic                     err_checksum_q, err_checksum_d;
  logic                     err_timeout_q, err_timeout_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic        byte_fire;
  logic        err_inc;
  logic [6:0]  byte_lsb;
  logic [15:0] csum;

  // Ready / valid are pure functions of state, so neither side sees a
  // combinational path through this block.
  assign byte_ready = (state_q == S_IDLE) || (state_q == S_RECEIVING);
  assign flit_valid = (state_q == S_OUTPUT);
  assign busy       = (state_q != S_IDLE);
  assign byte_fire  = byte_valid && byte_ready;

  assign flit_out     = flit_q;
  assign err_checksum = err_checksum_q;
  assign err_timeout  = err_timeout_q;
  assign err_count    = err_count_q;

  // Byte k lands in bits [127-8k:120-8k], i.e. LSB position 8*(15-k).
  assign byte_lsb = {LAST_IDX - idx_q, 3'b000};

  // Sum of the seven 16-bit words above the checksum field, modulo 2^16.
  always_comb begin
    csum = '0;
    for (int i = 1; i < 8; i++) begin
      csum = csum + flit_q[16*i +: 16];
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    tmo_d          = tmo_q;
    flit_d         = flit_q;
    err_checksum_d = 1'b0;
    err_timeout_d  = 1'b0;
    err_inc        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (byte_fire) begin
          // Start a fresh flit: clearing the lower bytes guarantees that
          // nothing from an earlier, dropped flit can leak through.
          flit_d  = {byte_data, 120'b0};
          idx_d   = 4'd1;
          tmo_d   = '0;
          state_d = S_RECEIVING;
        end
      end

      S_RECEIVING: begin
        if (byte_fire) begin
          flit_d[byte_lsb +: 8] = byte_data;
          tmo_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = S_CHECK;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (TMO_EN) begin
          if (tmo_q == TMO_LAST) begin
            flit_d        = '0;
            idx_d         = 4'd0;
            tmo_d         = '0;
            err_timeout_d = 1'b1;
            err_inc       = 1'b1;
            state_d       = S_IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end

      S_CHECK: begin
        if (csum == flit_q[15:0]) begin
          state_d = S_OUTPUT;
        end else begin
          flit_d         = '0;
          err_checksum_d = 1'b1;
          err_inc        = 1'b1;
          state_d        = S_IDLE;
        end
      end

      S_OUTPUT: begin
        // flit_q is untouched here, so flit_out stays stable until accepted.
        if (flit_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
        tmo_d   = '0;
      end
    endcase

    if (err_inc && (err_count_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= 4'd0;
      tmo_q          <= '0;
      flit_q         <= '0;
      err_checksum_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tmo_q          <= tmo_d;
      flit_q         <= flit_d;
      err_checksum_q <= err_checksum_d;
      err_timeout_q  <= err_timeout_d;
      err_count_q    <= err_count_d;
    end
  end

endmodule

// File: tb/tb_uart_flit_deserializer.sv
// -----------------------------------------------------------------------------
// tb_uart_flit_deserializer
//
// Directed bench for uart_flit_deserializer with TIMEOUT_CYCLES = 100.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_uart_flit_deserializer;

  localparam int TMO = 100;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic         flit_valid;
  logic [127:0] flit_out;
  logic         flit_ready;
  logic         err_checksum;
  logic         err_timeout;
  logic [7:0]   err_count;
  logic         busy;

  always #5 clk = ~clk;

  uart_flit_deserializer #(
    .TIMEOUT_CYCLES (TMO),
    .ERR_CNT_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .flit_valid   (flit_valid),
    .flit_out     (flit_out),
    .flit_ready   (flit_ready),
    .err_checksum (err_checksum),
    .err_timeout  (err_timeout),
    .err_count    (err_count),
    .busy         (busy)
  );

  // ---------------- vectors ----------------
  localparam logic [127:0] HEAD_OK  = 128'h10020300_00000000_00000000_00001302;
  localparam logic [127:0] HEAD_BAD = 128'h10020300_00000000_00000000_00001303;
  localparam logic [127:0] BP_FLIT  = 128'h20050700_00000000_00000000_00002705;
  localparam logic [127:0] WRAP_OK  = 128'hFFFF0001_00000000_00000000_00000000;

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [127:0] exp_q[$];
  logic [127:0] held;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    chk("byte_ready_on_send", {127'b0, byte_ready}, 128'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [127:0] f, input int n);
    for (int k = 0; k < n; k++) begin
      send_byte(f[8*(15-k) +: 8]);
    end
  endtask

  // Called right after the last byte edge: we are in the CHECK cycle.
  task automatic expect_pass(input string tag);
    logic [127:0] e;
    chk({tag, "_check_valid"}, {127'b0, flit_valid}, 128'd0);
    chk({tag, "_check_ready"}, {127'b0, byte_ready}, 128'd0);
    chk({tag, "_check_busy"},  {127'b0, busy},       128'd1);
    tick();
    e = exp_q.pop_front();
    chk({tag, "_valid"},  {127'b0, flit_valid},   128'd1);
    chk({tag, "_data"},   flit_out,               e);
    chk({tag, "_no_cks"}, {127'b0, err_checksum}, 128'd0);
    chk({tag, "_no_tmo"}, {127'b0, err_timeout},  128'd0);
  endtask

  task automatic expect_fail(input string tag, input logic [7:0] cnt);
    chk({tag, "_check_valid"}, {127'b0, flit_valid}, 128'd0);
    tick();
    chk({tag, "_cks_pulse"}, {127'b0, err_checksum}, 128'd1);
    chk({tag, "_no_tmo"},    {127'b0, err_timeout},  128'd0);
    chk({tag, "_no_valid"},  {127'b0, flit_valid},   128'd0);
    chk({tag, "_ready"},     {127'b0, byte_ready},   128'd1);
    chk({tag, "_count"},     {120'b0, err_count},    {120'b0, cnt});
    tick();
    chk({tag, "_cks_end"},   {127'b0, err_checksum}, 128'd0);
  endtask

  task automatic expect_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, {127'b0, byte_ready},   128'd1);
    chk({tag, "_flit_valid"}, {127'b0, flit_valid},   128'd0);
    chk({tag, "_flit_out"},   flit_out,               128'd0);
    chk({tag, "_err_cks"},    {127'b0, err_checksum}, 128'd0);
    chk({tag, "_err_tmo"},    {127'b0, err_timeout},  128'd0);
    chk({tag, "_err_count"},  {120'b0, err_count},    128'd0);
    chk({tag, "_busy"},       {127'b0, busy},         128'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    flit_ready = 1'b1;
    tick();
    tick();
    expect_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1. valid HEAD flit
    exp_q.push_back(HEAD_OK);
    send_bytes(HEAD_OK, 16);
    expect_pass("head");
    tick();
    chk("head_handshake_valid", {127'b0, flit_valid}, 128'd0);
    chk("head_handshake_busy",  {127'b0, busy},       128'd0);
    chk("head_err_count",       {120'b0, err_count},  128'd0);

    // 2. same stream, bad checksum byte
    send_bytes(HEAD_BAD, 16);
    expect_fail("bad_cks", 8'd1);

    // 3. backpressure for 50 cycles with a byte waiting
    flit_ready = 1'b0;
    exp_q.push_back(BP_FLIT);
    send_bytes(BP_FLIT, 16);
    expect_pass("bp");
    held       = flit_out;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("bp_stable",    flit_out,                 held);
      chk("bp_valid",     {127'b0, flit_valid},     128'd1);
      chk("bp_no_accept", {127'b0, byte_ready},     128'd0);
    end
    byte_valid = 1'b0;
    flit_ready = 1'b1;
    tick();
    chk("bp_release_valid", {127'b0, flit_valid}, 128'd0);
    chk("bp_release_ready", {127'b0, byte_ready}, 128'd1);
    chk("bp_release_busy",  {127'b0, busy},       128'd0);

    // 4. timeout after 7 bytes
    send_bytes(HEAD_OK, 7);
    for (int i = 1; i < TMO; i++) begin
      tick();
    end
    chk("tmo_before_pulse", {127'b0, err_timeout}, 128'd0);
    chk("tmo_before_busy",  {127'b0, busy},        128'd1);
    tick();
    chk("tmo_pulse",        {127'b0, err_timeout},  128'd1);
    chk("tmo_no_cks",       {127'b0, err_checksum}, 128'd0);
    chk("tmo_count",        {120'b0, err_count},    128'd2);
    chk("tmo_idle",         {127'b0, busy},         128'd0);
    tick();
    chk("tmo_pulse_end",    {127'b0, err_timeout},  128'd0);
    exp_q.push_back(HEAD_OK);
    send_bytes(HEAD_OK, 16);
    expect_pass("after_tmo");
    tick();

    // 5. checksum wraps modulo 2^16
    exp_q.push_back(WRAP_OK);
    send_bytes(WRAP_OK, 16);
    expect_pass("wrap");
    tick();

    // 6. saturation: 300 bad flits starting from err_count = 2
    for (int i = 0; i < 300; i++) begin
      send_bytes(HEAD_BAD, 16);
      tick();
      tick();
      if (i == 251) begin
        chk("sat_254", {120'b0, err_count}, 128'd254);
      end
    end
    chk("sat_255", {120'b0, err_count}, 128'd255);
    send_bytes(HEAD_BAD, 16);
    expect_fail("sat_hold", 8'd255);

    // 7. reset in the middle of a flit
    send_bytes(HEAD_OK, 9);
    chk("mid_busy", {127'b0, busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    expect_reset_outputs("mid_reset");
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(HEAD_OK);
    send_bytes(HEAD_OK, 16);
    expect_pass("post_reset");
    tick();
    chk("post_reset_count", {120'b0, err_count}, 128'd0);
    chk("post_reset_idle",  {127'b0, busy},      128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
